id_queue_decoder: RTL and testbench
===================================

ID_QUEUE_DECODER -- requirements
Module: id_queue_decoder

Interface
REQ-001 Parameter DEPTH, default 4, instruction-queue entries; power of two, at least 2.
REQ-002 Parameter XLEN, default 32, data/address width; instruction width fixed at 32.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 rdy  input  1  global enable; low freezes all state.
REQ-006 flush  input  1  discard all queued and staged instructions (branch redirect).
REQ-007 in_valid  input  1; in_ready  output  1; in_pc  input  XLEN; in_inst  input  32: fetch-side handshake and payload.
REQ-008 out_valid  output  1; out_ready  input  1: decode-side handshake.
REQ-009 out_pc  output  XLEN; out_opcode  output  7; out_funct3  output  3; out_alt  output  1 (inst[30]): decoded fields.
REQ-010 out_rs1, out_rs2, out_rd  output  5 each; out_re1, out_re2, out_we  output  1 each: register usage.
REQ-011 out_imm  output  XLEN  sign-extended immediate; out_illegal  output  1  unsupported encoding.
REQ-012 count  output  log2(DEPTH)+1  current queue occupancy, excluding output stage.

Function
REQ-013 Storage SHALL be a circular queue of DEPTH {pc, inst} entries with wrapping read/write pointers, followed by one registered output stage.
REQ-014 in_ready SHALL be (count != DEPTH) and rdy and !flush; a push occurs on a clock edge where in_valid and in_ready are both high.
REQ-015 Output stage SHALL load the decoded queue head on an edge where count>0, rdy high, flush low, and (out_valid low or out_ready high); this pops the head.
REQ-016 Push and pop in the same cycle SHALL leave count unchanged; pointers SHALL each advance modulo DEPTH.
REQ-017 On an edge with out_valid and out_ready high and no head available, out_valid SHALL clear.
REQ-018 Latency SHALL be exactly 2 cycles from push to out_valid when the queue is empty and the output stage is free; no bypass path.
REQ-019 Output fields SHALL stay stable while out_valid is high and out_ready is low.
REQ-020 Decode: LUI/AUIPC imm = {inst[31:12],12'b0}; JAL imm = J-type; JALR/load/OP-IMM (non-shift) imm = I-type; store imm = S-type; branch imm = B-type; shift-imm imm = zero-extended inst[24:20]; OP imm = 0; all sign-extended to XLEN.
REQ-021 re1 SHALL be 1 for JALR, branch, load, store, OP-IMM, OP; re2 SHALL be 1 for branch, store, OP; otherwise 0.
REQ-022 we SHALL be 1 for LUI, AUIPC, JAL, JALR, load, OP-IMM, OP only when rd != 0; otherwise 0.
REQ-023 illegal SHALL be 1 for unknown opcode, branch funct3 010/011, load funct3 011/110/111, store funct3 >= 011, and shift/OP funct7 other than 0000000 (0100000 allowed only for SRAI/SRA/SUB); illegal forces re1=re2=we=0.
REQ-024 flush SHALL, on the next edge, reset both pointers, set count=0 and clear out_valid; any concurrent push or pop is discarded.
REQ-025 rdy low SHALL hold pointers, queue contents, count and the output stage unchanged; flush and push are ignored.

Reset
REQ-026 On a rst edge: pointers=0, count=0, out_valid=0, all out_* fields=0, in_ready=1 after the edge; rst takes priority over flush and rdy.
REQ-027 Reset mid-operation SHALL drop all queued and staged instructions without emitting them.

Verification
REQ-028 Push pc=0x100, inst=0x00500093 with out_ready=1 -> out_valid 2 cycles later; rd=1, rs1=0, imm=5, re1=1, re2=0, we=1, illegal=0.
REQ-029 Push 0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFC, re1=re2=1, we=0; push 0x123452B7 -> imm=0x12345000, rd=5, we=1.
REQ-030 DEPTH=4, out_ready=0, continuous in_valid -> exactly 5 pushes accepted, in_ready low with count=4; raise out_ready -> entries emitted in order, pointers wrap correctly.
REQ-031 Queue holding 3 entries, out_valid=1, assert flush 1 cycle -> next cycle count=0, out_valid=0; a push accepted afterwards emits normally.
REQ-032 rdy=0 for 3 cycles mid-stream with in_valid=1, out_ready=1 -> count and outputs unchanged, no push or pop; resume with no loss or duplication.
REQ-033 Push 0x00000007 (bad opcode) and 0x40001033 (funct3 001 with funct7 0100000) -> illegal=1, we=re1=re2=0.

Source files
------------

// File: rtl/id_queue_decoder.sv
// Fetch-to-decode instruction queue: a circular {pc, inst} buffer whose head is
// decoded (RV32I subset) and captured in a single registered output stage.
module id_queue_decoder #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         in_pc,
  input  logic [31:0]             in_inst,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_pc,
  output logic [6:0]              out_opcode,
  output logic [2:0]              out_funct3,
  output logic                    out_alt,
  output logic [4:0]              out_rs1,
  output logic [4:0]              out_rs2,
  output logic [4:0]              out_rd,
  output logic                    out_re1,
  output logic                    out_re2,
  output logic                    out_we,
  output logic [XLEN-1:0]         out_imm,
  output logic                    out_illegal,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [XLEN-1:0] pc_mem_r   [DEPTH];
  logic [31:0]     inst_mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;

  logic            push_s;
  logic            pop_s;
  logic [31:0]     head_inst_s;
  logic [XLEN-1:0] head_pc_s;
  logic [6:0]      opc_s;
  logic [2:0]      f3_s;
  logic [6:0]      f7_s;
  logic [31:0]     imm32_s;
  logic [XLEN-1:0] imm_s;
  logic            re1_raw_s;
  logic            re2_raw_s;
  logic            wr_raw_s;
  logic            ill_s;

  assign in_ready    = (count != CW'(DEPTH)) && rdy && !flush;
  assign push_s      = in_valid && in_ready;
  assign pop_s       = (count != {CW{1'b0}}) && rdy && !flush && (!out_valid || out_ready);
  assign head_inst_s = inst_mem_r[rd_ptr_r];
  assign head_pc_s   = pc_mem_r[rd_ptr_r];
  assign opc_s       = head_inst_s[6:0];
  assign f3_s        = head_inst_s[14:12];
  assign f7_s        = head_inst_s[31:25];

  // Decode the queue head: immediate format, register usage and legality.
  always_comb begin
    imm32_s   = 32'd0;
    re1_raw_s = 1'b0;
    re2_raw_s = 1'b0;
    wr_raw_s  = 1'b0;
    ill_s     = 1'b0;
    case (opc_s)
      OPC_LUI, OPC_AUIPC: begin
        imm32_s  = {head_inst_s[31:12], 12'd0};
        wr_raw_s = 1'b1;
      end
      OPC_JAL: begin
        imm32_s  = {{11{head_inst_s[31]}}, head_inst_s[31], head_inst_s[19:12],
                    head_inst_s[20], head_inst_s[30:21], 1'b0};
        wr_raw_s = 1'b1;
      end
      OPC_JALR: begin
        imm32_s   = {{20{head_inst_s[31]}}, head_inst_s[31:20]};
        re1_raw_s = 1'b1;
        wr_raw_s  = 1'b1;
      end
      OPC_BRANCH: begin
        imm32_s   = {{19{head_inst_s[31]}}, head_inst_s[31], head_inst_s[7],
                     head_inst_s[30:25], head_inst_s[11:8], 1'b0};
        re1_raw_s = 1'b1;
        re2_raw_s = 1'b1;
        ill_s     = (f3_s == 3'b010) || (f3_s == 3'b011);
      end
      OPC_LOAD: begin
        imm32_s   = {{20{head_inst_s[31]}}, head_inst_s[31:20]};
        re1_raw_s = 1'b1;
        wr_raw_s  = 1'b1;
        ill_s     = (f3_s == 3'b011) || (f3_s == 3'b110) || (f3_s == 3'b111);
      end
      OPC_STORE: begin
        imm32_s   = {{20{head_inst_s[31]}}, head_inst_s[31:25], head_inst_s[11:7]};
        re1_raw_s = 1'b1;
        re2_raw_s = 1'b1;
        ill_s     = (f3_s >= 3'b011);
      end
      OPC_OPIMM: begin
        re1_raw_s = 1'b1;
        wr_raw_s  = 1'b1;
        if (f3_s == 3'b001) begin
          imm32_s = {27'd0, head_inst_s[24:20]};
          ill_s   = (f7_s != 7'b0000000);
        end else if (f3_s == 3'b101) begin
          imm32_s = {27'd0, head_inst_s[24:20]};
          ill_s   = (f7_s != 7'b0000000) && (f7_s != 7'b0100000);
        end else begin
          imm32_s = {{20{head_inst_s[31]}}, head_inst_s[31:20]};
          ill_s   = 1'b0;
        end
      end
      OPC_OP: begin
        re1_raw_s = 1'b1;
        re2_raw_s = 1'b1;
        wr_raw_s  = 1'b1;
        ill_s     = !((f7_s == 7'b0000000) ||
                      ((f7_s == 7'b0100000) && ((f3_s == 3'b000) || (f3_s == 3'b101))));
      end
      default: begin
        ill_s = 1'b1;
      end
    endcase
    imm_s       = {XLEN{imm32_s[31]}};
    imm_s[31:0] = imm32_s;
  end

  // Queue storage write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      pc_mem_r[wr_ptr_r]   <= in_pc;
      inst_mem_r[wr_ptr_r] <= in_inst;
    end
  end

  // Pointers, occupancy and output stage; rst beats flush, which beats push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count       <= {CW{1'b0}};
      out_valid   <= 1'b0;
      out_pc      <= {XLEN{1'b0}};
      out_opcode  <= 7'd0;
      out_funct3  <= 3'd0;
      out_alt     <= 1'b0;
      out_rs1     <= 5'd0;
      out_rs2     <= 5'd0;
      out_rd      <= 5'd0;
      out_re1     <= 1'b0;
      out_re2     <= 1'b0;
      out_we      <= 1'b0;
      out_imm     <= {XLEN{1'b0}};
      out_illegal <= 1'b0;
    end else if (rdy) begin
      if (flush) begin
        wr_ptr_r  <= {AW{1'b0}};
        rd_ptr_r  <= {AW{1'b0}};
        count     <= {CW{1'b0}};
        out_valid <= 1'b0;
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + AW'(1'b1);
        end
        if (pop_s) begin
          rd_ptr_r    <= rd_ptr_r + AW'(1'b1);
          out_valid   <= 1'b1;
          out_pc      <= head_pc_s;
          out_opcode  <= opc_s;
          out_funct3  <= f3_s;
          out_alt     <= head_inst_s[30];
          out_rs1     <= head_inst_s[19:15];
          out_rs2     <= head_inst_s[24:20];
          out_rd      <= head_inst_s[11:7];
          out_re1     <= re1_raw_s && !ill_s;
          out_re2     <= re2_raw_s && !ill_s;
          out_we      <= wr_raw_s && !ill_s && (head_inst_s[11:7] != 5'd0);
          out_imm     <= imm_s;
          out_illegal <= ill_s;
        end else if (out_valid && out_ready) begin
          out_valid <= 1'b0;
        end
        if (push_s && !pop_s) begin
          count <= count + CW'(1'b1);
        end else if (pop_s && !push_s) begin
          count <= count - CW'(1'b1);
        end
      end
    end
  end

endmodule

// File: tb/tb_id_queue_decoder.sv
// Directed bench for id_queue_decoder: decode vectors, fill/drain ordering,
// flush, rdy stall and mid-stream reset, all against hand-computed values.
module tb_id_queue_decoder;
  logic        clk = 1'b0;
  logic        rst, rdy, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_inst, out_pc, out_imm;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic        out_alt, out_re1, out_re2, out_we, out_illegal;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [2:0]  count;

  int checks_n = 0;
  int errors_n = 0;
  int n;
  int pidx;
  int exp_idx [9] = '{-1, 0, 1, 1, 1, 1, 2, 3, 4};
  logic rdy_pat [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  id_queue_decoder #(.DEPTH(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_alt(out_alt),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_re1(out_re1), .out_re2(out_re2), .out_we(out_we),
    .out_imm(out_imm), .out_illegal(out_illegal), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_n++;
    if (obs !== exp) begin
      errors_n++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Push one instruction into an idle pipe; returns when it should be staged.
  task automatic send(input logic [31:0] pc, input logic [31:0] inst);
    in_valid  = 1'b1;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("latency_one_cycle", out_valid, 1'b0);
    step();
  endtask

  task automatic chk_dec(input string t, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic re1, input logic re2, input logic we, input logic ill);
    check({t, "_valid"}, out_valid, 1'b1);
    check({t, "_pc"}, out_pc, pc);
    check({t, "_imm"}, out_imm, imm);
    check({t, "_rd"}, out_rd, rd);
    check({t, "_rs1"}, out_rs1, rs1);
    check({t, "_rs2"}, out_rs2, rs2);
    check({t, "_regs"}, {out_re1, out_re2, out_we, out_illegal}, {re1, re2, we, ill});
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_pc = 32'd0; in_inst = 32'd0; out_ready = 1'b0;
    @(negedge clk);
    step();
    check("rst_valid", out_valid, 1'b0);
    check("rst_count", count, 3'd0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_fields", {out_pc, out_imm, out_rd, out_opcode}, 76'd0);
    rst = 1'b0;

    // Decode vectors
    send(32'h100, 32'h00500093);
    chk_dec("addi", 32'h100, 32'd5, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    check("addi_opcode", out_opcode, 7'h13);
    step();
    check("addi_drained", out_valid, 1'b0);
    send(32'h104, 32'hFE000EE3);
    chk_dec("beq", 32'h104, 32'hFFFFFFFC, 5'd29, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    send(32'h108, 32'h123452B7);
    chk_dec("lui", 32'h108, 32'h12345000, 5'd5, 5'd8, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    send(32'h10C, 32'h4030D093);
    chk_dec("srai", 32'h10C, 32'd3, 5'd1, 5'd1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    check("srai_f3_alt", {out_funct3, out_alt}, 4'b1011);
    step();
    send(32'h110, 32'hFE20AC23);
    chk_dec("sw", 32'h110, 32'hFFFFFFF8, 5'd24, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    send(32'h114, 32'h00000007);
    chk_dec("badopc", 32'h114, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    send(32'h118, 32'h40001033);
    chk_dec("sll_alt", 32'h118, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    send(32'h11C, 32'h400000B3);
    chk_dec("sub", 32'h11C, 32'd0, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    step();

    // Fill with the consumer stalled, then drain in order across the wrap
    out_ready = 1'b0;
    in_valid  = 1'b1;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      in_pc   = 32'h200 + 32'(n * 4);
      in_inst = 32'h00000093 | (32'(n) << 20);
      if (in_ready) n++;
      step();
    end
    in_valid = 1'b0;
    check("fill_pushes", n, 5);
    check("fill_count", count, 3'd4);
    check("fill_in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("drain_valid", out_valid, 1'b1);
      check("drain_pc", out_pc, 32'h200 + 32'(k * 4));
      check("drain_imm", out_imm, 32'(k));
      step();
    end
    check("drain_empty_valid", out_valid, 1'b0);
    check("drain_empty_count", count, 3'd0);

    // Flush with three queued entries and one staged
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      in_pc    = 32'h300 + 32'(c * 4);
      in_inst  = 32'h00000093;
      step();
    end
    in_valid = 1'b0;
    check("preflush_count", count, 3'd3);
    check("preflush_valid", out_valid, 1'b1);
    flush    = 1'b1;
    in_valid = 1'b1;
    #1;
    check("flush_in_ready", in_ready, 1'b0);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_count", count, 3'd0);
    check("flush_valid", out_valid, 1'b0);
    send(32'h380, 32'h123452B7);
    chk_dec("postflush", 32'h380, 32'h12345000, 5'd5, 5'd8, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    step();

    // Streaming with a three-cycle rdy stall
    out_ready = 1'b1;
    in_valid  = 1'b1;
    pidx = 0;
    for (int i = 0; i < 9; i++) begin
      in_pc   = 32'h400 + 32'(pidx * 4);
      in_inst = 32'h00000093 | (32'(pidx) << 20);
      rdy     = rdy_pat[i];
      #1;
      check("stall_in_ready", in_ready, rdy_pat[i]);
      step();
      if (rdy_pat[i]) pidx++;
      check("stall_valid", out_valid, exp_idx[i] >= 0);
      if (exp_idx[i] >= 0) check("stall_pc", out_pc, 32'h400 + 32'(exp_idx[i] * 4));
      check("stall_count", count, 3'd1);
    end
    in_valid = 1'b0;
    step();
    check("stall_tail_pc", out_pc, 32'h414);
    check("stall_tail_count", count, 3'd0);
    step();
    check("stall_tail_empty", out_valid, 1'b0);

    // Reset mid-operation, asserted while rdy is low
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_pc    = 32'h500 + 32'(c * 4);
      in_inst  = 32'h00500093;
      step();
    end
    in_valid = 1'b0;
    check("prerst_valid", out_valid, 1'b1);
    rdy = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    rdy = 1'b1;
    #1;
    check("midrst_count", count, 3'd0);
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_fields", {out_pc, out_imm, out_rd}, 69'd0);
    check("midrst_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("midrst_no_emit", out_valid, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
    $finish;
  end
endmodule
